// File: rtl/scan_mux.sv
// Channel selector with a manual mode and a round-robin scan mode.
// Outputs are registered one cycle after the select decision.
module scan_mux #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 4,
  localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS*WIDTH-1:0]   data_in,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        mode,
  input  logic                        hold,
  output logic [WIDTH-1:0]            out,
  output logic [SEL_W-1:0]            out_ch,
  output logic                        out_valid,
  output logic                        wrap
);

  localparam int unsigned DC_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned LEAVES = 1 << SEL_W;

  typedef enum logic {
    ST_MAN  = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
  logic [DC_W-1:0]   dcnt_q, dcnt_d;
  logic              wrap_pend_q, wrap_pend_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic              wrap_q, wrap_d;

  logic [SEL_W-1:0]  mux_sel;
  logic [WIDTH-1:0]  mux_out;
  logic              scan_active;
  logic [SEL_W-1:0]  scan_ch;
  logic [DC_W-1:0]   scan_dcnt;
  logic              scan_pend;
  logic              sel_in_range;

  // Binary select tree: level 0 is the root, level SEL_W holds the padded channel leaves.
  for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
    logic [WIDTH-1:0] node [1 << l];
    if (l == SEL_W) begin : g_leaf
      for (genvar k = 0; k < (1 << l); k++) begin : g_k
        if (k < CHANNELS) begin : g_real
          assign node[k] = data_in[k*WIDTH +: WIDTH];
        end else begin : g_pad
          assign node[k] = '0;
        end
      end
    end else begin : g_mux
      for (genvar k = 0; k < (1 << l); k++) begin : g_k
        assign node[k] = mux_sel[SEL_W-1-l] ? g_lvl[l+1].node[2*k+1] : g_lvl[l+1].node[2*k];
      end
    end
  end

  assign mux_out = g_lvl[0].node[0];

  // Entering scan from manual behaves as if the counters were freshly cleared.
  always_comb begin
    scan_active  = (state_q == ST_SCAN);
    scan_ch      = scan_active ? cur_ch_q : '0;
    scan_dcnt    = scan_active ? dcnt_q : '0;
    scan_pend    = scan_active & wrap_pend_q;
    sel_in_range = ({1'b0, sel} < (SEL_W+1)'(CHANNELS));
  end

  always_comb begin
    state_d     = mode ? ST_SCAN : ST_MAN;
    cur_ch_d    = cur_ch_q;
    dcnt_d      = dcnt_q;
    wrap_pend_d = 1'b0;
    mux_sel     = sel;
    out_ch_d    = sel;
    out_valid_d = sel_in_range;
    wrap_d      = 1'b0;

    if (mode) begin
      mux_sel     = scan_ch;
      out_ch_d    = scan_ch;
      out_valid_d = 1'b1;
      wrap_d      = scan_pend;
      cur_ch_d    = scan_ch;
      dcnt_d      = scan_dcnt;
      if (!hold) begin
        if (scan_dcnt == DC_W'(DWELL - 1)) begin
          dcnt_d = '0;
          if (scan_ch == SEL_W'(CHANNELS - 1)) begin
            cur_ch_d    = '0;
            wrap_pend_d = 1'b1;
          end else begin
            cur_ch_d = scan_ch + SEL_W'(1);
          end
        end else begin
          dcnt_d = scan_dcnt + DC_W'(1);
        end
      end
    end

    out_d = mux_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_MAN;
      cur_ch_q    <= '0;
      dcnt_q      <= '0;
      wrap_pend_q <= 1'b0;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      dcnt_q      <= dcnt_d;
      wrap_pend_q <= wrap_pend_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each data channel (>=1).
REQ-002 Parameter CHANNELS, default 4, number of input channels (>=1, need not be a power of two).
REQ-003 Parameter DWELL, default 4, clock cycles spent on each channel in scan mode (>=1).
REQ-004 Derived SEL_W = max(1, ceil(log2(CHANNELS))); it is not user-overridable.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 data_in  input  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  manual channel select.
REQ-009 mode  input  1  0 = manual select, 1 = automatic round-robin scan.
REQ-010 hold  input  1  in scan mode, freezes channel/dwell counters; ignored in manual mode.
REQ-011 out  output  WIDTH  registered selected data.
REQ-012 out_ch  output  SEL_W  registered index of the channel that produced out.
REQ-013 out_valid  output  1  registered; 1 when out holds data from a legal channel.
REQ-014 wrap  output  1  registered one-cycle pulse when scan advances from channel CHANNELS-1 to 0.

Function
REQ-015 The block SHALL hold a two-state FSM: MAN (mode=0 behaviour) and SCAN (mode=1 behaviour), with next state taken directly from mode each cycle.
REQ-016 MAN->SCAN transition SHALL load channel counter cur_ch=0 and dwell counter dcnt=0, so the first SCAN cycle selects channel 0.
REQ-017 SCAN->MAN transition SHALL take effect on the next edge; the cycle after it, out reflects data_in[sel]; cur_ch and dcnt are then don't-care until the next MAN->SCAN.
REQ-018 Output latency SHALL be exactly one cycle: out/out_ch/out_valid at edge n+1 reflect data_in, sel, cur_ch as sampled at edge n.
REQ-019 In MAN with sel < CHANNELS: out = channel sel, out_ch = sel, out_valid = 1.
REQ-020 In MAN with sel >= CHANNELS (non-power-of-two CHANNELS): out = 0, out_ch = sel, out_valid = 0.
REQ-021 In SCAN: out = channel cur_ch, out_ch = cur_ch, out_valid = 1 every cycle, including while hold=1.
REQ-022 In SCAN with hold=0: dcnt increments each cycle; when dcnt = DWELL-1, dcnt returns to 0 and cur_ch advances by 1.
REQ-023 cur_ch SHALL wrap from CHANNELS-1 to 0 (never reaching CHANNELS); wrap SHALL be 1 in the output cycle that first shows channel 0 after the wrap, else 0.
REQ-024 In SCAN with hold=1: cur_ch and dcnt SHALL not change; wrap = 0; data continues to be resampled from the held channel.
REQ-025 DWELL=1: cur_ch SHALL advance every unheld cycle.
REQ-026 CHANNELS=1: cur_ch stays 0; wrap pulses once every DWELL unheld cycles.
REQ-027 hold and a dwell-expiry in the same cycle: hold SHALL win; no advance, no wrap.
REQ-028 mode change and dwell-expiry in the same cycle: the mode transition rule (REQ-016/017) SHALL win.
REQ-029 Per-channel selection SHALL be a generated parametrised mux tree; no width truncation of data.

Reset
REQ-030 With reset=1 at a rising edge: state = MAN, cur_ch = 0, dcnt = 0, out = 0, out_ch = 0, out_valid = 0, wrap = 0.
REQ-031 Reset SHALL override all other inputs, including mid-scan and mid-dwell; the first non-reset edge behaves per mode as if entering from MAN (mode=1 starts at channel 0 per REQ-016).
REQ-032 Outputs SHALL remain at reset values until the first edge with reset=0.

Verification (WIDTH=1, CHANNELS=4, DWELL=4 unless stated)
REQ-033 Manual: data_in=4'b1010, mode=0, sel=0..3 on successive cycles -> out = 0,1,0,1 one cycle later each, out_valid=1, out_ch tracks sel.
REQ-034 Scan: data_in=4'b0110, mode=1 from reset release -> out_ch 0,0,0,0,1,1,1,1,2..., out follows data; wrap=1 only on the cycle out_ch returns to 0 (cycle 17).
REQ-035 Hold: during scan at out_ch=2, dcnt=1, assert hold 5 cycles -> out_ch stays 2, wrap=0; after release channel 2 persists 2 more cycles then 3.
REQ-036 Mid-scan reset: reset=1 for one edge at out_ch=3 -> next cycle all outputs 0/invalid; with mode=1 held, scan restarts at channel 0 with full dwell.
REQ-037 Out-of-range: CHANNELS=3, WIDTH=8, mode=0, sel=3 -> out=8'h00, out_valid=0, out_ch=3; sel=2 -> channel 2 data, out_valid=1.
REQ-038 Edge params: DWELL=1, CHANNELS=1 -> out_ch always 0, wrap=1 every cycle in SCAN; toggling mode each cycle yields no X and obeys REQ-016/017.
